// File: rtl/qddc.sv
// Quadrature digital down-converter: per-rail 4-stage CIC decimator (R=32, M=1)
// taking 14-bit I/Q samples to 16-bit I/Q words with a one-cycle valid strobe.
module qddc #(
  parameter int ISZ   = 14,
  parameter int OSZ   = 16,
  parameter int N     = 4,
  parameter int RLOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [ISZ-1:0] in_i,
  input  logic signed [ISZ-1:0] in_q,
  input  logic                  in_valid,
  output logic signed [OSZ-1:0] out_i,
  output logic signed [OSZ-1:0] out_q,
  output logic                  out_valid
);

  localparam int W = ISZ + N * RLOG2;

  logic signed [ISZ-1:0] in_i_q, in_q_q;
  logic                  in_valid_q;
  logic signed [W-1:0]   ext_i, ext_q;

  logic signed [W-1:0]   integ_i_q [N];
  logic signed [W-1:0]   integ_q_q [N];
  logic signed [W-1:0]   comb_i_q  [N];
  logic signed [W-1:0]   comb_q_q  [N];
  logic signed [W-1:0]   dly_i_q   [N];
  logic signed [W-1:0]   dly_q_q   [N];
  logic signed [W-1:0]   comb_in_i [N];
  logic signed [W-1:0]   comb_in_q [N];

  logic [RLOG2-1:0]      cnt_q, cnt_d;
  // stb_q[0] is the decimation strobe; stb_q[k] enables comb k+1, stb_q[N] is out_valid
  logic [N:0]            stb_q, stb_d;

  always_comb begin
    ext_i = {{(W-ISZ){in_i_q[ISZ-1]}}, in_i_q};
    ext_q = {{(W-ISZ){in_q_q[ISZ-1]}}, in_q_q};
    comb_in_i[0] = integ_i_q[N-1];
    comb_in_q[0] = integ_q_q[N-1];
    for (int unsigned k = 1; k < N; k++) begin
      comb_in_i[k] = comb_i_q[k-1];
      comb_in_q[k] = comb_q_q[k-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid_q) cnt_d = cnt_q + 1'b1;
    stb_d = {stb_q[N-1:0], in_valid_q && (cnt_q == '1)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_i_q     <= '0;
      in_q_q     <= '0;
      in_valid_q <= 1'b0;
      cnt_q      <= '0;
      stb_q      <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        integ_i_q[k] <= '0;
        integ_q_q[k] <= '0;
        comb_i_q[k]  <= '0;
        comb_q_q[k]  <= '0;
        dly_i_q[k]   <= '0;
        dly_q_q[k]   <= '0;
      end
    end else begin
      in_i_q     <= in_i;
      in_q_q     <= in_q;
      in_valid_q <= in_valid;
      cnt_q      <= cnt_d;
      stb_q      <= stb_d;
      // integrators wrap modulo 2^W by design
      if (in_valid_q) begin
        integ_i_q[0] <= integ_i_q[0] + ext_i;
        integ_q_q[0] <= integ_q_q[0] + ext_q;
        for (int unsigned k = 1; k < N; k++) begin
          integ_i_q[k] <= integ_i_q[k] + integ_i_q[k-1];
          integ_q_q[k] <= integ_q_q[k] + integ_q_q[k-1];
        end
      end
      for (int unsigned k = 0; k < N; k++) begin
        if (stb_q[k]) begin
          comb_i_q[k] <= comb_in_i[k] - dly_i_q[k];
          comb_q_q[k] <= comb_in_q[k] - dly_q_q[k];
          dly_i_q[k]  <= comb_in_i[k];
          dly_q_q[k]  <= comb_in_q[k];
        end
      end
    end
  end

  always_comb begin
    out_i     = comb_i_q[N-1][W-1 -: OSZ];
    out_q     = comb_q_q[N-1][W-1 -: OSZ];
    out_valid = stb_q[N];
  end

endmodule

// File: tb/tb_qddc.sv
// Self-checking bench for qddc: impulse-response CIC model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_qddc;

  localparam int ISZ   = 14;
  localparam int OSZ   = 16;
  localparam int N     = 4;
  localparam int RLOG2 = 5;
  localparam int R     = 32;
  localparam int HLEN  = N * (R - 1) + 1;
  localparam int SHIFT = ISZ + N * RLOG2 - OSZ;

  logic                  clk = 1'b0;
  logic                  reset;
  logic signed [ISZ-1:0] in_i, in_q;
  logic                  in_valid;
  logic signed [OSZ-1:0] out_i, out_q;
  logic                  out_valid;

  always #5 clk = ~clk;

  qddc #(.ISZ(ISZ), .OSZ(OSZ), .N(N), .RLOG2(RLOG2)) dut (
    .clk(clk), .reset(reset), .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
    .out_i(out_i), .out_q(out_q), .out_valid(out_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  // Model: output n = sum of consumed samples weighted by the 4-fold boxcar
  // impulse response, offset by the N-1 sample pipelining of the integrators.
  longint h4 [HLEN];
  int     hist_i[$], hist_q[$];
  typedef struct { int t; int oi; int oq; } ev_t;
  ev_t    evq[$];
  bit     pend = 0;
  int     pend_i, pend_q;
  int     cyc = 0;
  int     exp_i = 0, exp_q = 0;
  bit     exp_v = 0;
  bit     started = 0;

  function automatic int model_out(input bit qrail, input int n);
    longint acc;
    int     idx;
    acc = 0;
    for (int d = 0; d < HLEN; d++) begin
      idx = n * R - (N - 1) - d;
      if (idx >= 1)
        acc += longint'(qrail ? hist_q[idx-1] : hist_i[idx-1]) * h4[d];
    end
    return int'(acc >>> SHIFT);
  endfunction

  always @(posedge clk) begin
    ev_t ev;
    cyc++;
    if (reset) begin
      started = 1;
      hist_i.delete();
      hist_q.delete();
      evq.delete();
      pend  = 0;
      exp_i = 0;
      exp_q = 0;
      exp_v = 0;
    end else begin
      exp_v = 0;
      if (evq.size() > 0 && evq[0].t == cyc) begin
        exp_v = 1;
        exp_i = evq[0].oi;
        exp_q = evq[0].oq;
        void'(evq.pop_front());
      end
      if (pend) begin
        hist_i.push_back(pend_i);
        hist_q.push_back(pend_q);
        if (hist_i.size() % R == 0) begin
          ev.t  = cyc + N;
          ev.oi = model_out(1'b0, hist_i.size() / R);
          ev.oq = model_out(1'b1, hist_i.size() / R);
          evq.push_back(ev);
        end
      end
      pend   = in_valid;
      pend_i = in_i;
      pend_q = in_q;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", out_valid, exp_v);
      chk("out_i", out_i, exp_i);
      chk("out_q", out_q, exp_q);
    end
  end

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_i     = '0;
    in_q     = '0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_strobe(input string nm, input int maxc, output bit ok);
    ok = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        return;
      end
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    longint tmp [HLEN];
    bit     ok;
    longint t_last, t0;
    int     ns;

    for (int d = 0; d < HLEN; d++) h4[d] = (d < R) ? 1 : 0;
    repeat (N - 1) begin
      for (int d = 0; d < HLEN; d++) begin
        tmp[d] = 0;
        for (int m = 0; m < R; m++)
          if (d - m >= 0) tmp[d] += h4[d-m];
      end
      h4 = tmp;
    end
    chk("h4_28", h4[28], 4495);
    chk("h4_60", h4[60], 21731);

    // reset / idle
    do_reset(4);
    ns = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (out_valid) ns++;
    end
    chk("idle_strobes", ns, 0);
    chk("idle_out_i", out_i, 0);
    chk("idle_out_q", out_q, 0);

    // DC settle, continuous valid
    do_reset(2);
    in_i = 14'sd1000; in_q = -14'sd1000; in_valid = 1'b1;
    t_last = 0;
    for (int s = 1; s <= 8; s++) begin
      wait_strobe("dc", 80, ok);
      if (!ok) break;
      if (s > 1) chk("dc_period", $time - t_last, R * 10);
      t_last = $time;
      if (s >= 5) begin
        chk("dc_out_i", out_i, 4000);
        chk("dc_out_q", out_q, -4000);
      end
    end

    // full scale, long enough for the upper integrators to wrap many times
    do_reset(2);
    in_i = 14'sd8191; in_q = -14'sd8192; in_valid = 1'b1;
    for (int s = 1; s <= 100; s++) begin
      wait_strobe("fs", 80, ok);
      if (!ok) break;
      if (s == 10 || s == 100) begin
        chk("fs_out_i", out_i, 32764);
        chk("fs_out_q", out_q, -32768);
      end
    end

    // gapped valid: every other clock
    do_reset(2);
    in_i = 14'sd1000; in_q = -14'sd1000; in_valid = 1'b1;
    ns = 0; t_last = 0;
    for (int c = 0; c < 64 * 8 + 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ns++;
        if (ns > 1) chk("gap_period", $time - t_last, 2 * R * 10);
        t_last = $time;
        if (ns >= 5) begin
          chk("gap_out_i", out_i, 4000);
          chk("gap_out_q", out_q, -4000);
        end
      end
      in_valid = ~in_valid;
    end
    chk("gap_strobes", ns, 8);

    // impulse
    do_reset(2);
    in_i = 14'sd8191; in_q = '0; in_valid = 1'b1;
    @(negedge clk);
    in_i = '0;
    for (int s = 1; s <= 6; s++) begin
      wait_strobe("imp", 80, ok);
      if (!ok) break;
      if (s == 1) chk("imp_1", out_i, 140);
      if (s == 2) chk("imp_2", out_i, 679);
      if (s == 5) chk("imp_5", out_i, 0);
      chk("imp_q", out_q, 0);
    end

    // reset in the middle of a block (counter at 17)
    do_reset(2);
    in_i = 14'sd1000; in_q = -14'sd1000; in_valid = 1'b1;
    repeat (R + 17 + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    t0 = $time;
    chk("mid_out_i", out_i, 0);
    chk("mid_out_q", out_q, 0);
    chk("mid_out_valid", out_valid, 0);
    wait_strobe("mid", 80, ok);
    if (ok) chk("mid_latency", $time - t0, (R + N + 1) * 10);

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
